// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes and register specifiers.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    // A specifier names real storage only if it is not NONE and lies below nregs.
    function automatic logic idx_valid(input logic [3:0] idx, input int unsigned nregs);
        return (idx != REG_NONE) && (32'(idx) < nregs);
    endfunction

endpackage

// File: rtl/y86_src_sel.sv
// Decode-stage source register selection from icode and the rA/rB specifiers.
module y86_src_sel
    import y86_pkg::*;
#(
    parameter int unsigned SP_IDX = 4
) (
    input  logic [3:0] icode,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] srcA,
    output logic [3:0] srcB
);

    localparam logic [3:0] SP = 4'(SP_IDX);

    always_comb begin
        srcA = REG_NONE;
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
            I_RET, I_POPQ:                      srcA = SP;
            default:                            srcA = REG_NONE;
        endcase
    end

    always_comb begin
        srcB = REG_NONE;
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcB = SP;
            default:                            srcB = REG_NONE;
        endcase
    end

endmodule

// File: rtl/y86_regfile.sv
// Y86-64 register file: decoded A/B reads, debug read, and E/M clocked write ports.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int unsigned     WIDTH    = 64,
    parameter int unsigned     NREGS    = 15,
    parameter int unsigned     SP_IDX   = 4,
    parameter logic [WIDTH-1:0] SP_RESET = '0,
    parameter int unsigned     BYPASS   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             wr_en,
    input  logic [3:0]       dst_e,
    input  logic [WIDTH-1:0] val_e,
    input  logic [3:0]       dst_m,
    input  logic [WIDTH-1:0] val_m,
    input  logic [3:0]       dbg_idx,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [WIDTH-1:0] dbg_val
);

    localparam int unsigned NPORTS = 3;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [3:0]       rd_idx [NPORTS];
    logic [WIDTH-1:0] rd_val [NPORTS];

    y86_src_sel #(
        .SP_IDX (SP_IDX)
    ) u_src_sel (
        .icode (icode),
        .rA    (rA),
        .rB    (rB),
        .srcA  (srcA),
        .srcB  (srcB)
    );

    // M is applied after E so that popq %rsp leaves the popped value in SP.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && dst_e == 4'(i)) regs_d[i] = val_e;
            if (wr_en && dst_m == 4'(i)) regs_d[i] = val_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_idx[0] = srcA;
    assign rd_idx[1] = srcB;
    assign rd_idx[2] = dbg_idx;

    // Array read with optional same-cycle forwarding, M taking priority over E.
    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            rd_val[p] = '0;
            if (idx_valid(rd_idx[p], NREGS)) begin
                rd_val[p] = regs_q[rd_idx[p]];
                if (BYPASS != 0 && wr_en) begin
                    if (rd_idx[p] == dst_m)      rd_val[p] = val_m;
                    else if (rd_idx[p] == dst_e) rd_val[p] = val_e;
                end
            end
        end
    end

    assign valA    = rd_val[0];
    assign valB    = rd_val[1];
    assign dbg_val = rd_val[2];

endmodule

// File: tb/tb_y86_regfile.sv
// Directed bench for y86_regfile; one BYPASS=0 and one BYPASS=1 instance share stimulus.
module tb_y86_regfile;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   icode, rA, rB, dst_e, dst_m, dbg_idx;
    logic         wr_en;
    logic [W-1:0] val_e, val_m;

    logic [W-1:0] nb_valA, nb_valB, nb_dbg, bp_valA, bp_valB, bp_dbg;
    logic [3:0]   nb_srcA, nb_srcB, bp_srcA, bp_srcB;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [W-1:0] NEG90 = 64'hFFFF_FFFF_FFFF_FFA6;

    always #5 clk = ~clk;

    y86_regfile #(.WIDTH(W), .NREGS(15), .SP_IDX(4), .SP_RESET(64'd256), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .wr_en(wr_en),
        .dst_e(dst_e), .val_e(val_e), .dst_m(dst_m), .val_m(val_m), .dbg_idx(dbg_idx),
        .valA(nb_valA), .valB(nb_valB), .srcA(nb_srcA), .srcB(nb_srcB), .dbg_val(nb_dbg)
    );

    y86_regfile #(.WIDTH(W), .NREGS(15), .SP_IDX(4), .SP_RESET(64'd256), .BYPASS(1)) u_bp (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .wr_en(wr_en),
        .dst_e(dst_e), .val_e(val_e), .dst_m(dst_m), .val_m(val_m), .dbg_idx(dbg_idx),
        .valA(bp_valA), .valB(bp_valB), .srcA(bp_srcA), .srcB(bp_srcB), .dbg_val(bp_dbg)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; dst_e = 4'hF; dst_m = 4'hF; val_e = '0; val_m = '0;
    endtask

    initial begin
        rst_n = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; dbg_idx = 4'h0;
        idle();

        // 1: reset contents
        #2;
        for (int i = 0; i < 15; i++) begin
            dbg_idx = 4'(i);
            #1;
            chk($sformatf("reset_reg%0d", i), nb_dbg, (i == 4) ? 64'd256 : 64'd0);
        end
        dbg_idx = 4'hF; #1;
        chk("reset_regF", nb_dbg, 64'd0);

        @(negedge clk); rst_n = 1'b1;

        // 2: write reg2/reg3 then opq read
        @(negedge clk);
        wr_en = 1'b1; dst_e = 4'd2; val_e = NEG90; dst_m = 4'd3; val_m = 64'd54;
        @(negedge clk);
        idle(); icode = 4'h6; rA = 4'd2; rB = 4'd3;
        #1;
        chk("opq_valA", nb_valA, NEG90);
        chk("opq_valB", nb_valB, 64'd54);
        chk("opq_srcA", 64'(nb_srcA), 64'd2);
        chk("opq_srcB", 64'(nb_srcB), 64'd3);
        chk("opq_bp_valB", bp_valB, 64'd54);
        chk("opq_bp_srcA", 64'(bp_srcA), 64'd2);
        chk("opq_bp_srcB", 64'(bp_srcB), 64'd3);

        icode = 4'h9; #1;
        chk("ret_srcA", 64'(nb_srcA), 64'd4);
        chk("ret_srcB", 64'(nb_srcB), 64'd4);
        chk("ret_valA", nb_valA, 64'd256);
        icode = 4'h8; #1;
        chk("call_srcA", 64'(nb_srcA), 64'hF);
        chk("call_srcB", 64'(nb_srcB), 64'd4);
        chk("call_valA", nb_valA, 64'd0);
        icode = 4'h5; #1;
        chk("mrmov_srcA", 64'(nb_srcA), 64'hF);
        chk("mrmov_srcB", 64'(nb_srcB), 64'd3);
        icode = 4'hA; #1;
        chk("push_srcA", 64'(nb_srcA), 64'd2);
        chk("push_srcB", 64'(nb_srcB), 64'd4);
        icode = 4'h0; #1;
        chk("halt_srcA", 64'(nb_srcA), 64'hF);
        chk("halt_srcB", 64'(nb_srcB), 64'hF);

        // 3: popq %rsp, M beats E
        @(negedge clk);
        wr_en = 1'b1; dst_e = 4'd4; val_e = 64'd264; dst_m = 4'd4; val_m = 64'd77; dbg_idx = 4'd4;
        #1;
        chk("popq_bp_fwd", bp_dbg, 64'd77);
        chk("popq_nb_old", nb_dbg, 64'd256);
        @(negedge clk);
        idle(); #1;
        chk("popq_reg4", nb_dbg, 64'd77);

        // 4: wr_en=0 blocks writes; F destinations ignored
        @(negedge clk);
        wr_en = 1'b0; dst_e = 4'd1; val_e = 64'd99; dbg_idx = 4'd1;
        #1;
        chk("noen_bp_nofwd", bp_dbg, 64'd0);
        @(negedge clk);
        idle(); #1;
        chk("noen_reg1", nb_dbg, 64'd0);
        wr_en = 1'b1; dst_e = 4'hF; val_e = 64'hDEAD; dst_m = 4'hF; val_m = 64'hBEEF; dbg_idx = 4'hF;
        #1;
        chk("dstF_bp_dbgF", bp_dbg, 64'd0);
        @(negedge clk);
        idle();
        for (int i = 0; i < 15; i++) begin
            dbg_idx = 4'(i);
            #1;
            chk($sformatf("dstF_reg%0d", i), nb_dbg,
                (i == 2) ? NEG90 : (i == 3) ? 64'd54 : (i == 4) ? 64'd77 : 64'd0);
        end

        // 5: same-cycle forwarding onto valA
        @(negedge clk);
        icode = 4'h6; rA = 4'd5; rB = 4'd3;
        wr_en = 1'b1; dst_e = 4'd5; val_e = 64'd21;
        #1;
        chk("byp_valA_bp", bp_valA, 64'd21);
        chk("byp_valA_nb_old", nb_valA, 64'd0);
        @(negedge clk);
        idle(); #1;
        chk("byp_valA_nb_next", nb_valA, 64'd21);
        chk("byp_valA_bp_next", bp_valA, 64'd21);

        // 6: reset 1 ns before an edge that would write reg7
        @(negedge clk);
        wr_en = 1'b1; dst_e = 4'd7; val_e = 64'h1234; dbg_idx = 4'd7;
        #4 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_reg7", nb_dbg, 64'd0);
        dbg_idx = 4'd4; #1;
        chk("rstmid_reg4", nb_dbg, 64'd256);
        dbg_idx = 4'd2; #1;
        chk("rstmid_reg2", nb_dbg, 64'd0);
        @(negedge clk);
        idle(); rst_n = 1'b1;
        @(negedge clk);
        dbg_idx = 4'd7; #1;
        chk("rstmid_reg7_after", nb_dbg, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
